// File: rtl/imem_arbiter.sv
// Shares the instruction ROM read port between fetch and debug readers.
// Fetch has priority; a starvation counter forces debug through after STARVE_MAX denials.
//
// state    | meaning
// OWN_NONE | no read in flight, no valid pulse this cycle
// OWN_IF   | fetch read in flight, if_valid pulses this cycle
// OWN_DBG  | debug read in flight, dbg_valid pulses this cycle
module imem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_BYTES = 128,
    parameter int STARVE_MAX  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_data,
    output logic              if_stall,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_gnt,
    output logic              dbg_valid,
    output logic [DATA_W-1:0] dbg_data,
    output logic              addr_err,
    output logic [ADDR_W-1:0] rom_adr,
    input  logic [DATA_W-1:0] rom_dout
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DBG  = 2'd2
    } own_t;

    localparam logic [3:0]        STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [ADDR_W-1:0] DEPTH_LIM  = ADDR_W'(DEPTH_BYTES);

    own_t              own_q;
    own_t              own_d;
    logic [3:0]        starve_cnt;
    logic [3:0]        starve_nxt;
    logic              addr_ok;
    logic [DATA_W-1:0] word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own_q <= OWN_NONE;
        end else begin
            own_q <= own_d;
        end
    end

    always_comb begin
        dbg_gnt    = dbg_req & (~if_req | (starve_cnt == STARVE_LIM));
        if_gnt     = if_req & ~dbg_gnt;
        if_stall   = if_req & ~if_gnt;
        rom_adr    = dbg_gnt ? dbg_addr : if_addr;
        starve_nxt = 4'd0;
        own_d      = OWN_NONE;
        if (dbg_req && !dbg_gnt) begin
            starve_nxt = (starve_cnt == STARVE_LIM) ? starve_cnt : starve_cnt + 4'd1;
        end
        if (if_gnt) begin
            own_d = OWN_IF;
        end else if (dbg_gnt) begin
            own_d = OWN_DBG;
        end
    end

    assign if_valid  = (own_q == OWN_IF);
    assign dbg_valid = (own_q == OWN_DBG);

    // Out-of-range or misaligned reads return a NOP instead of aliased ROM data.
    assign addr_ok = (rom_adr[1:0] == 2'b00) && (rom_adr < DEPTH_LIM);
    assign word    = addr_ok ? rom_dout : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 4'd0;
            addr_err   <= 1'b0;
            if_data    <= '0;
            dbg_data   <= '0;
        end else begin
            starve_cnt <= starve_nxt;
            addr_err   <= (if_gnt | dbg_gnt) & ~addr_ok;
            if (own_d == OWN_IF) begin
                if_data <= word;
            end
            if (own_d == OWN_DBG) begin
                dbg_data <= word;
            end
        end
    end

endmodule
